mem_arbiter: RTL and testbench

//  Shares the single four-bank memory between the instruction-cache and data-cache controllers.

---
 rtl/mem_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one four-bank memory between the instruction-cache and data-cache
// controllers. Only one controller owns the memory at a time. The owner keeps
// the grant for a whole transaction (eviction plus fill bursts). The owner's
// beat commands go straight to memory. Read data, bank busy and stall come
// straight back to the owner. The side without the grant sees a memory that is
// fully busy and stalled, so its wait states stay parked until it is granted.

module mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int BANKS    = 4,
  parameter int MAX_HOLD = 64
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_rd,
  input  logic              i_wr,
  input  logic              i_lock,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              i_gnt,
  output logic [DATA_W-1:0] i_rdata,
  output logic [BANKS-1:0]  i_busy,
  output logic              i_stall,

  input  logic              d_rd,
  input  logic              d_wr,
  input  logic              d_lock,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic [DATA_W-1:0] d_rdata,
  output logic [BANKS-1:0]  d_busy,
  output logic              d_stall,

  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [BANKS-1:0]  mem_busy,
  input  logic              mem_stall,

  output logic              arb_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_e;

  // The hold counter is 7 bits wide. It saturates at all-ones, so it never
  // wraps back under the limit during a very long transaction.
  localparam logic [6:0] HOLD_LIMIT = 7'(MAX_HOLD);
  localparam logic [6:0] HOLD_SAT   = 7'h7F;

  // last_gnt encoding: 0 means the I side was granted last, 1 means the D side.
  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

  state_e     state_q, state_d;
  logic       last_gnt_q, last_gnt_d;
  logic [6:0] hold_cnt_q, hold_cnt_d;
  logic       arb_err_q, arb_err_d;

  logic reqI;
  logic reqD;
  logic busyAny;
  logic releaseI;
  logic releaseD;

  // A side wants memory if it has a beat pending or is inside a transaction.
  assign reqI    = i_rd | i_wr | i_lock;
  assign reqD    = d_rd | d_wr | d_lock;
  assign busyAny = |mem_busy;

  // A grant ends only when the owner has no beat, no lock, and every bank is idle.
  assign releaseI = ~i_lock & ~i_rd & ~i_wr & ~busyAny;
  assign releaseD = ~d_lock & ~d_rd & ~d_wr & ~busyAny;

  // State, fairness memory, hold counter and sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      last_gnt_q <= LAST_I;
      hold_cnt_q <= 7'd0;
      arb_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      hold_cnt_q <= hold_cnt_d;
      arb_err_q  <= arb_err_d;
    end
  end

  // Next-state logic: grant arbitration, release handling, and hold/conflict error detection.
  // The IDLE cycle that issues a grant counts as the first hold cycle.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    hold_cnt_d = hold_cnt_q;
    arb_err_d  = arb_err_q;

    case (state_q)
      IDLE: begin
        if (!busyAny) begin
          if (reqI && reqD) begin
            state_d    = (last_gnt_q == LAST_I) ? GNT_D : GNT_I;
            hold_cnt_d = 7'd1;
          end else if (reqI) begin
            state_d    = GNT_I;
            hold_cnt_d = 7'd1;
          end else if (reqD) begin
            state_d    = GNT_D;
            hold_cnt_d = 7'd1;
          end
        end
      end

      GNT_I: begin
        if (hold_cnt_q != HOLD_SAT) begin
          hold_cnt_d = hold_cnt_q + 7'd1;
        end
        if (i_rd && i_wr) begin
          arb_err_d = 1'b1;
        end
        if (releaseI) begin
          last_gnt_d = LAST_I;
          hold_cnt_d = 7'd0;
          state_d    = reqD ? GNT_D : IDLE;
        end
      end

      GNT_D: begin
        if (hold_cnt_q != HOLD_SAT) begin
          hold_cnt_d = hold_cnt_q + 7'd1;
        end
        if (d_rd && d_wr) begin
          arb_err_d = 1'b1;
        end
        if (releaseD) begin
          last_gnt_d = LAST_D;
          hold_cnt_d = 7'd0;
          state_d    = reqI ? GNT_I : IDLE;
        end
      end

      default: begin
        state_d    = IDLE;
        hold_cnt_d = 7'd0;
      end
    endcase

    // Holding the memory too long is flagged. The grant itself is never revoked.
    if (hold_cnt_d >= HOLD_LIMIT) begin
      arb_err_d = 1'b1;
    end
  end

  // Forward the owner's beat to memory with no added latency.
  // A conflicting read+write beat is dropped, not guessed at.
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    case (state_q)
      GNT_I: begin
        mem_rd    = i_rd & ~i_wr;
        mem_wr    = i_wr & ~i_rd;
        mem_addr  = i_addr;
        mem_wdata = i_wdata;
      end
      GNT_D: begin
        mem_rd    = d_rd & ~d_wr;
        mem_wr    = d_wr & ~d_rd;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end
      default: begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
      end
    endcase
  end

  // Return path: only the owner sees the real memory status.
  // The other side is held in its wait-on-busy state.
  always_comb begin
    i_gnt   = 1'b0;
    d_gnt   = 1'b0;
    i_rdata = '0;
    d_rdata = '0;
    i_busy  = '1;
    d_busy  = '1;
    i_stall = 1'b1;
    d_stall = 1'b1;

    if (state_q == GNT_I) begin
      i_gnt   = 1'b1;
      i_rdata = mem_rdata;
      i_busy  = mem_busy;
      i_stall = mem_stall;
    end

    if (state_q == GNT_D) begin
      d_gnt   = 1'b1;
      d_rdata = mem_rdata;
      d_busy  = mem_busy;
      d_stall = mem_stall;
    end
  end

  assign arb_err = arb_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed-vector bench for mem_arbiter. Inputs change one time unit after
// each rising edge. Outputs are sampled after the inputs have settled, which
// keeps every sample away from the clock edge.

module tb_mem_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int BANKS  = 4;

  logic              clk;
  logic              rst;
  logic              i_rd, i_wr, i_lock;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_wdata;
  logic              i_gnt;
  logic [DATA_W-1:0] i_rdata;
  logic [BANKS-1:0]  i_busy;
  logic              i_stall;
  logic              d_rd, d_wr, d_lock;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic [DATA_W-1:0] d_rdata;
  logic [BANKS-1:0]  d_busy;
  logic              d_stall;
  logic              mem_rd, mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [BANKS-1:0]  mem_busy;
  logic              mem_stall;
  logic              arb_err;

  int checkCount = 0;
  int errorCount = 0;

  mem_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .BANKS   (BANKS),
    .MAX_HOLD(64)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_rd     (i_rd),
    .i_wr     (i_wr),
    .i_lock   (i_lock),
    .i_addr   (i_addr),
    .i_wdata  (i_wdata),
    .i_gnt    (i_gnt),
    .i_rdata  (i_rdata),
    .i_busy   (i_busy),
    .i_stall  (i_stall),
    .d_rd     (d_rd),
    .d_wr     (d_wr),
    .d_lock   (d_lock),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rdata  (d_rdata),
    .d_busy   (d_busy),
    .d_stall  (d_stall),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_busy (mem_busy),
    .mem_stall(mem_stall),
    .arb_err  (arb_err)
  );

  // Free-running clock with rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends, even if the sequence stalls.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish expected finish by 200000");
    $fatal(1, "[TB] time limit expired");
  end

  // Compare one observed value against its expected value and count the comparison.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive the request-side control lines and the bank-busy input together.
  task automatic applyStimulus(input logic iRd, input logic iWr, input logic iLock,
                               input logic dRd, input logic dWr, input logic dLock,
                               input logic [BANKS-1:0] busy);
    i_rd     = iRd;
    i_wr     = iWr;
    i_lock   = iLock;
    d_rd     = dRd;
    d_wr     = dWr;
    d_lock   = dLock;
    mem_busy = busy;
  endtask

  // Advance one clock. Return one unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between clock edges. This is called one unit after an edge.
  task automatic resetDut();
    rst = 1'b0;
    #3;
    rst = 1'b1;
  endtask

  initial begin
    rst       = 1'b0;
    i_addr    = '0;
    i_wdata   = '0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_rdata = 16'hBEEF;
    mem_stall = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 4'h0);

    // Values while reset is held.
    #2;
    checkOutput("rst_i_gnt", {31'd0, i_gnt}, 32'd0);
    checkOutput("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
    checkOutput("rst_i_busy", {28'd0, i_busy}, 32'hF);
    checkOutput("rst_d_stall", {31'd0, d_stall}, 32'd1);
    checkOutput("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    checkOutput("rst_d_rdata", {16'd0, d_rdata}, 32'd0);
    checkOutput("rst_arb_err", {31'd0, arb_err}, 32'd0);
    rst = 1'b1;
    tick();

    // 1: a single D read is granted on the next cycle and forwarded combinationally.
    d_addr = 16'h1230;
    applyStimulus(0, 0, 0, 1, 0, 0, 4'h0);
    #1 checkOutput("t1_no_gnt_yet", {31'd0, d_gnt}, 32'd0);
    tick();
    checkOutput("t1_d_gnt", {31'd0, d_gnt}, 32'd1);
    checkOutput("t1_mem_rd", {31'd0, mem_rd}, 32'd1);
    checkOutput("t1_mem_addr", {16'd0, mem_addr}, 32'h1230);
    checkOutput("t1_i_busy", {28'd0, i_busy}, 32'hF);
    checkOutput("t1_i_stall", {31'd0, i_stall}, 32'd1);
    checkOutput("t1_d_stall", {31'd0, d_stall}, 32'd0);
    checkOutput("t1_d_rdata", {16'd0, d_rdata}, 32'hBEEF);
    checkOutput("t1_i_rdata", {16'd0, i_rdata}, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 4'h0);
    tick();
    checkOutput("t1_release", {31'd0, d_gnt}, 32'd0);

    // 2: both locks rise after reset, so D wins. I follows with no idle gap.
    resetDut();
    tick();
    applyStimulus(0, 0, 1, 0, 0, 1, 4'h0);
    tick();
    checkOutput("t2_d_first", {30'd0, i_gnt, d_gnt}, 32'b01);
    tick();
    applyStimulus(0, 0, 1, 0, 0, 0, 4'h0);
    #1 checkOutput("t2_d_still", {30'd0, i_gnt, d_gnt}, 32'b01);
    tick();
    checkOutput("t2_i_next", {30'd0, i_gnt, d_gnt}, 32'b10);

    // 3: alternating locks give the order D, I, D, I. The grants never overlap.
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) applyStimulus(0, 0, 0, 0, 0, 1, 4'h0);
      else            applyStimulus(0, 0, 1, 0, 0, 0, 4'h0);
      tick();
      checkOutput($sformatf("t3_order%0d", k), {30'd0, i_gnt, d_gnt},
                  (k % 2 == 0) ? 32'b01 : 32'b10);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 4'h0);
    tick();
    checkOutput("t3_idle", {30'd0, i_gnt, d_gnt}, 32'b00);

    // 4: lock falls while a bank is busy, so the grant is kept until busy clears.
    applyStimulus(0, 0, 0, 0, 0, 1, 4'h0);
    tick();
    checkOutput("t4_d_gnt", {31'd0, d_gnt}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 4'b0010);
      #1 checkOutput($sformatf("t4_hold%0d", k), {31'd0, d_gnt}, 32'd1);
      checkOutput($sformatf("t4_dbusy%0d", k), {28'd0, d_busy}, 32'h2);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 4'h0);
    #1 checkOutput("t4_last_hold", {31'd0, d_gnt}, 32'd1);
    tick();
    checkOutput("t4_released", {31'd0, d_gnt}, 32'd0);

    // IDLE does not grant while any bank is busy.
    i_addr = 16'h0555;
    applyStimulus(1, 0, 0, 0, 0, 0, 4'hF);
    tick();
    checkOutput("t4_idle_busy", {31'd0, i_gnt}, 32'd0);
    applyStimulus(1, 0, 0, 0, 0, 0, 4'h0);
    tick();
    checkOutput("t4_idle_free", {31'd0, i_gnt}, 32'd1);
    checkOutput("t4_i_addr", {16'd0, mem_addr}, 32'h0555);
    applyStimulus(0, 0, 0, 0, 0, 0, 4'h0);
    tick();

    // 5: a long D lock raises arb_err from cycle 64. The grant stays and the error is sticky.
    applyStimulus(0, 0, 0, 0, 0, 1, 4'h0);
    tick();
    repeat (62) tick();
    checkOutput("t5_err_c63", {31'd0, arb_err}, 32'd0);
    tick();
    checkOutput("t5_err_c64", {31'd0, arb_err}, 32'd1);
    checkOutput("t5_gnt_c64", {31'd0, d_gnt}, 32'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 4'h0);
    #1 checkOutput("t5_gnt_c65", {31'd0, d_gnt}, 32'd1);
    tick();
    checkOutput("t5_released", {31'd0, d_gnt}, 32'd0);
    checkOutput("t5_sticky", {31'd0, arb_err}, 32'd1);

    // 6: reset in the middle of a D write burst drops every output at once.
    resetDut();
    checkOutput("t6_err_cleared", {31'd0, arb_err}, 32'd0);
    tick();
    d_addr  = 16'h0040;
    d_wdata = 16'hA5A5;
    applyStimulus(0, 0, 0, 0, 1, 0, 4'h0);
    tick();
    checkOutput("t6_mem_wr", {31'd0, mem_wr}, 32'd1);
    checkOutput("t6_wdata", {16'd0, mem_wdata}, 32'hA5A5);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("t6_rst_wr", {31'd0, mem_wr}, 32'd0);
    checkOutput("t6_rst_gnt", {31'd0, d_gnt}, 32'd0);
    checkOutput("t6_rst_wdata", {16'd0, mem_wdata}, 32'd0);
    checkOutput("t6_rst_dbusy", {28'd0, d_busy}, 32'hF);
    rst = 1'b1;
    i_addr = 16'h0777;
    applyStimulus(1, 0, 0, 0, 0, 0, 4'h0);
    tick();
    checkOutput("t6_i_gnt", {31'd0, i_gnt}, 32'd1);
    checkOutput("t6_i_rd", {31'd0, mem_rd}, 32'd1);
    checkOutput("t6_i_addr", {16'd0, mem_addr}, 32'h0777);
    applyStimulus(0, 0, 0, 0, 0, 0, 4'h0);
    tick();

    // A granted read+write conflict forwards nothing and sets arb_err.
    applyStimulus(0, 0, 0, 1, 1, 0, 4'h0);
    tick();
    checkOutput("t6_conf_gnt", {31'd0, d_gnt}, 32'd1);
    checkOutput("t6_conf_cmd", {30'd0, mem_rd, mem_wr}, 32'b00);
    tick();
    checkOutput("t6_conf_err", {31'd0, arb_err}, 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 4'h0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
